// File: rtl/writeback_stage.sv
// writeback_stage: load extraction, exception detection and registered register-file write with retire counter
module writeback_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [4:0]  i_rd,
    input  logic        i_wr_rd,
    input  logic        i_is_load,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_load_data,
    output logic [4:0]  o_rd,
    output logic [31:0] o_rd_wdata,
    output logic        o_w_en,
    output logic        o_exc,
    output logic [1:0]  o_exc_cause,
    output logic [63:0] o_retire_count
);
    logic        accept, illegal, misaligned, exc;
    logic [1:0]  off;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ld, result;
    always_comb begin
        accept     = i_valid & ~i_stall & ~i_flush;
        off        = i_alu_result[1:0];
        b          = i_load_data[{off, 3'b000} +: 8];
        h          = off[1] ? i_load_data[31:16] : i_load_data[15:0];
        illegal    = i_is_load & (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111);
        misaligned = i_is_load & ((i_funct3[1:0] == 2'b01 && off[0]) || (i_funct3 == 3'b010 && off != 2'b00));
        exc        = accept & (illegal | misaligned);
        ld         = i_funct3 == 3'b000 ? {{24{b[7]}}, b} :
                     i_funct3 == 3'b100 ? {24'b0, b} :
                     i_funct3 == 3'b001 ? {{16{h[15]}}, h} :
                     i_funct3 == 3'b101 ? {16'b0, h} : i_load_data;
        result     = i_is_load ? ld : i_alu_result;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd           <= '0;
            o_rd_wdata     <= '0;
            o_w_en         <= 1'b0;
            o_exc          <= 1'b0;
            o_exc_cause    <= 2'b00;
            o_retire_count <= '0;
        end else begin
            o_w_en      <= accept & ~exc & i_wr_rd & (i_rd != 5'd0);
            o_exc       <= exc;
            o_exc_cause <= exc ? (illegal ? 2'b10 : 2'b01) : 2'b00;
            if (accept & ~exc) begin
                o_rd           <= i_rd;
                o_rd_wdata     <= result;
                o_retire_count <= o_retire_count + 64'd1;
            end
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors with a scoreboard queue checked by a per-cycle monitor
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0, i_stall = 1'b0, i_flush = 1'b0;
    logic [4:0]  i_rd = '0;
    logic        i_wr_rd = 1'b0, i_is_load = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_alu_result = '0, i_load_data = '0;
    logic [4:0]  o_rd;
    logic [31:0] o_rd_wdata;
    logic        o_w_en, o_exc;
    logic [1:0]  o_exc_cause;
    logic [63:0] o_retire_count;

    writeback_stage dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
        .i_rd(i_rd), .i_wr_rd(i_wr_rd), .i_is_load(i_is_load), .i_funct3(i_funct3),
        .i_alu_result(i_alu_result), .i_load_data(i_load_data), .o_rd(o_rd),
        .o_rd_wdata(o_rd_wdata), .o_w_en(o_w_en), .o_exc(o_exc), .o_exc_cause(o_exc_cause),
        .o_retire_count(o_retire_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        e;
        logic [1:0]  c;
        logic [63:0] n;
    } exp_t;

    exp_t        q[$];
    int          errors = 0, checks = 0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_wdata = '0;
    logic [63:0] m_cnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("w_en", {63'b0, o_w_en}, {63'b0, e.w});
            chk("rd", {59'b0, o_rd}, {59'b0, e.rd});
            chk("wdata", {32'b0, o_rd_wdata}, {32'b0, e.d});
            chk("exc", {63'b0, o_exc}, {63'b0, e.e});
            chk("cause", {62'b0, o_exc_cause}, {62'b0, e.c});
            chk("count", o_retire_count, e.n);
        end
    end

    // drive one cycle of inputs with the hand-computed outcome, then advance past the edge
    task automatic step(input logic v, input logic s, input logic f, input logic [4:0] rd,
                        input logic wr, input logic ld, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] data,
                        input logic e_w, input logic [1:0] e_c, input logic [31:0] e_d, input logic e_ret);
        i_valid = v; i_stall = s; i_flush = f; i_rd = rd; i_wr_rd = wr; i_is_load = ld;
        i_funct3 = f3; i_alu_result = alu; i_load_data = data;
        if (e_ret) begin
            m_rd = rd;
            m_wdata = e_d;
            m_cnt = m_cnt + 64'd1;
        end
        q.push_back('{w: e_w, rd: m_rd, d: m_wdata, e: (e_c != 2'b00), c: e_c, n: m_cnt});
        @(posedge clk);
        #2;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd"}, {59'b0, o_rd}, 64'd0);
        chk({tag, "_wdata"}, {32'b0, o_rd_wdata}, 64'd0);
        chk({tag, "_w_en"}, {63'b0, o_w_en}, 64'd0);
        chk({tag, "_exc"}, {63'b0, o_exc}, 64'd0);
        chk({tag, "_cause"}, {62'b0, o_exc_cause}, 64'd0);
        chk({tag, "_count"}, o_retire_count, 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk_zero("reset");
        rst = 1'b0;
        //   v  s  f  rd     wr ld f3      alu            data           w  cause  wdata          ret
        step(1, 0, 0, 5'd5,  1, 0, 3'b000, 32'h1234_5678, 32'h0,         1, 2'b00, 32'h1234_5678, 1);
        step(1, 0, 0, 5'd1,  1, 1, 3'b000, 32'h0000_1003, 32'h80FF_0000, 1, 2'b00, 32'hFFFF_FF80, 1);
        step(1, 0, 0, 5'd2,  1, 1, 3'b100, 32'h0000_1003, 32'h80FF_0000, 1, 2'b00, 32'h0000_0080, 1);
        step(1, 0, 0, 5'd3,  1, 1, 3'b101, 32'h0000_1002, 32'h80FF_0000, 1, 2'b00, 32'h0000_80FF, 1);
        step(1, 0, 0, 5'd4,  1, 1, 3'b001, 32'h0000_2000, 32'h1234_8001, 1, 2'b00, 32'hFFFF_8001, 1);
        step(1, 0, 0, 5'd6,  1, 1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1, 2'b00, 32'hDEAD_BEEF, 1);
        step(1, 0, 0, 5'd8,  1, 1, 3'b000, 32'h0000_0001, 32'h0000_7F00, 1, 2'b00, 32'h0000_007F, 1);
        step(1, 0, 0, 5'd9,  1, 1, 3'b001, 32'h0000_0002, 32'h7FFF_0000, 1, 2'b00, 32'h0000_7FFF, 1);
        step(1, 0, 0, 5'd10, 1, 1, 3'b010, 32'h0000_0102, 32'hAAAA_AAAA, 0, 2'b01, 32'h0,         0);
        step(1, 0, 0, 5'd11, 1, 1, 3'b011, 32'h0000_0101, 32'hAAAA_AAAA, 0, 2'b10, 32'h0,         0);
        step(1, 0, 0, 5'd11, 1, 1, 3'b110, 32'h0000_0100, 32'hAAAA_AAAA, 0, 2'b10, 32'h0,         0);
        step(1, 0, 0, 5'd12, 1, 1, 3'b101, 32'h0000_0101, 32'hAAAA_AAAA, 0, 2'b01, 32'h0,         0);
        step(1, 0, 0, 5'd13, 1, 0, 3'b111, 32'h0000_0003, 32'h0,         1, 2'b00, 32'h0000_0003, 1);
        step(1, 1, 0, 5'd14, 1, 0, 3'b000, 32'h1111_1111, 32'h0,         0, 2'b00, 32'h0,         0);
        step(1, 0, 1, 5'd14, 1, 1, 3'b111, 32'h2222_2221, 32'h0,         0, 2'b00, 32'h0,         0);
        step(1, 0, 0, 5'd0,  1, 0, 3'b000, 32'h0000_0055, 32'h0,         0, 2'b00, 32'h0000_0055, 1);
        step(0, 0, 0, 5'd15, 1, 0, 3'b000, 32'h3333_3333, 32'h0,         0, 2'b00, 32'h0,         0);
        step(1, 0, 0, 5'd7,  0, 0, 3'b000, 32'hCAFE_F00D, 32'h0,         0, 2'b00, 32'hCAFE_F00D, 1);
        step(1, 0, 0, 5'd16, 1, 0, 3'b000, 32'h0BAD_0001, 32'h0,         1, 2'b00, 32'h0BAD_0001, 1);
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        m_rd = '0; m_wdata = '0; m_cnt = '0;
        step(1, 0, 0, 5'd20, 1, 0, 3'b000, 32'h0000_00AA, 32'h0,         1, 2'b00, 32'h0000_00AA, 1);
        force dut.o_retire_count = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.o_retire_count;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        step(1, 0, 0, 5'd21, 1, 0, 3'b000, 32'h0000_00BB, 32'h0,         1, 2'b00, 32'h0000_00BB, 1);
        step(1, 0, 0, 5'd22, 1, 0, 3'b000, 32'h0000_00CC, 32'h0,         1, 2'b00, 32'h0000_00CC, 1);
        i_valid = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
